// File: rtl/dmem_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_rd_ctrl
//  Description : Read-side controller for the data memory. It accepts one CPU
//                load at a time and checks the request's region, alignment
//                and size. A legal load issues a one-cycle read strobe to the
//                synchronous RAM, waits MEM_LAT cycles and then returns the
//                byte, halfword or word, zero- or sign-extended, together
//                with a one-cycle valid strobe. An illegal load is answered
//                in the next cycle with rd_err_o=1 and no RAM access.
//  Option      : DMEM_RD_HOLD_EN - adds a one-word last-read buffer. A
//                repeated load of the same word is served from the buffer
//                without a RAM access. Snooped store-path writes to that word
//                invalidate the buffer.
//  Ports       : clk, rst_n                  clock, async active-low reset
//                rd_req_i/rd_addr_i/rd_size_i/rd_sign_i  CPU load request
//                busy_o                     controller not idle (CPU stalls)
//                rd_valid_o/rd_data_o/rd_err_o   load response
//                mem_en_o/mem_addr_o/mem_rdata_i RAM read port
//                wr_en_i/wr_addr_i          snooped store-path write
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_rd_ctrl #(
    parameter int         MEM_LAT = 1,     // 1..4
    parameter int         AW      = 10,
    parameter logic [3:0] REGION  = 4'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_req_i,
    input  logic [31:0]   rd_addr_i,
    input  logic [1:0]    rd_size_i,
    input  logic          rd_sign_i,
    output logic          busy_o,
    output logic          rd_valid_o,
    output logic [31:0]   rd_data_o,
    output logic          rd_err_o,
    output logic          mem_en_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [31:0]   mem_rdata_i,
    input  logic          wr_en_i,
    input  logic [31:0]   wr_addr_i
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic [1:0]    lo_q;
    logic [1:0]    size_q;
    logic          sign_q;
    logic          busy_q;
    logic          rd_valid_q;
    logic [31:0]   rd_data_q;
    logic          rd_err_q;
    logic          mem_en_q;
    logic [AW-1:0] mem_addr_q;

    logic          req_err_d;
    logic [31:0]   mem_data_d;

    // Pick the addressed lane out of a little-endian word and extend it.
    function automatic logic [31:0] f_extract(input logic [31:0] w,
                                              input logic [1:0]  lo,
                                              input logic [1:0]  sz,
                                              input logic        sg);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{24{sg & b[7]}}, b};
            2'b01:   r = {{16{sg & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign req_err_d = (rd_addr_i[31:28] != REGION)
                     | (rd_size_i == 2'b11)
                     | ((rd_size_i == 2'b01) & rd_addr_i[0])
                     | ((rd_size_i == 2'b10) & (rd_addr_i[1:0] != 2'b00));

    assign mem_data_d = f_extract(mem_rdata_i, lo_q, size_q, sign_q);

`ifdef DMEM_RD_HOLD_EN
    logic [29:0] req_tag_q;
    logic [29:0] buf_tag_q;
    logic [31:0] buf_data_q;
    logic        buf_vld_q;
    logic        hit_d;

    // A store to the requested word in the request cycle forces a miss.
    assign hit_d = buf_vld_q && (buf_tag_q == rd_addr_i[31:2])
                && !(wr_en_i && (wr_addr_i[31:2] == rd_addr_i[31:2]));
`else
    logic unused_snoop;
    assign unused_snoop = &{1'b0, wr_en_i, wr_addr_i, rd_addr_i};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            lo_q       <= 2'b00;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
            rd_err_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
`ifdef DMEM_RD_HOLD_EN
            req_tag_q  <= 30'd0;
            buf_tag_q  <= 30'd0;
            buf_data_q <= 32'd0;
            buf_vld_q  <= 1'b0;
`endif
        end else begin
            mem_en_q   <= 1'b0;
            rd_valid_q <= 1'b0;
`ifdef DMEM_RD_HOLD_EN
            if (wr_en_i && (wr_addr_i[31:2] == buf_tag_q)) begin
                buf_vld_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (rd_req_i) begin
                        busy_q <= 1'b1;
                        if (req_err_d) begin
                            state_q    <= RESP;
                            rd_valid_q <= 1'b1;
                            rd_err_q   <= 1'b1;
                            rd_data_q  <= 32'd0;
`ifdef DMEM_RD_HOLD_EN
                        end else if (hit_d) begin
                            state_q    <= RESP;
                            rd_valid_q <= 1'b1;
                            rd_err_q   <= 1'b0;
                            rd_data_q  <= f_extract(buf_data_q, rd_addr_i[1:0],
                                                    rd_size_i, rd_sign_i);
`endif
                        end else begin
                            state_q    <= REQ;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= rd_addr_i[AW+1:2];
                            lo_q       <= rd_addr_i[1:0];
                            size_q     <= rd_size_i;
                            sign_q     <= rd_sign_i;
`ifdef DMEM_RD_HOLD_EN
                            req_tag_q  <= rd_addr_i[31:2];
`endif
                        end
                    end
                end
                REQ: begin
                    state_q <= WAIT;
                    cnt_q   <= 3'd1;
                end
                WAIT: begin
                    // Data is valid in the MEM_LAT-th cycle after the strobe.
                    if (cnt_q == LAT) begin
                        state_q    <= RESP;
                        rd_valid_q <= 1'b1;
                        rd_err_q   <= 1'b0;
                        rd_data_q  <= mem_data_d;
`ifdef DMEM_RD_HOLD_EN
                        // Fill wins over stale invalidation, but a matching
                        // write in the fill cycle leaves the entry invalid.
                        buf_tag_q  <= req_tag_q;
                        buf_data_q <= mem_rdata_i;
                        buf_vld_q  <= !(wr_en_i && (wr_addr_i[31:2] == req_tag_q));
`endif
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_err_o   = rd_err_q;
    assign mem_en_o   = mem_en_q;
    assign mem_addr_o = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_rd_ctrl
//  Description : Directed bench for dmem_rd_ctrl. Two instances (MEM_LAT=1
//                and MEM_LAT=3) share the request inputs, each with its own
//                RAM model whose data is valid only in the MEM_LAT-th cycle
//                after the strobe. Honours DMEM_RD_HOLD_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_rd_ctrl;

`ifdef DMEM_RD_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic        rd_sign;
    logic        wr_en;
    logic [31:0] wr_addr;

    logic        busy1, valid1, err1, en1;
    logic [31:0] data1, rdata1;
    logic [9:0]  maddr1;
    logic        busy3, valid3, err3, en3;
    logic [31:0] data3, rdata3;
    logic [9:0]  maddr3;

    logic [31:0] ram [0:15];
    logic [31:0] p1;
    logic [31:0] p3 [0:2];

    int  n_vec = 0;
    int  n_bad = 0;
    bit  mvld  = 1'b0;
    logic [29:0] mtag = 30'd0;

    always #5 clk = ~clk;

    dmem_rd_ctrl #(.MEM_LAT(1), .AW(10), .REGION(4'h0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_size_i(rd_size), .rd_sign_i(rd_sign), .busy_o(busy1),
        .rd_valid_o(valid1), .rd_data_o(data1), .rd_err_o(err1),
        .mem_en_o(en1), .mem_addr_o(maddr1), .mem_rdata_i(rdata1),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr));

    dmem_rd_ctrl #(.MEM_LAT(3), .AW(10), .REGION(4'h0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .rd_size_i(rd_size), .rd_sign_i(rd_sign), .busy_o(busy3),
        .rd_valid_o(valid3), .rd_data_o(data3), .rd_err_o(err3),
        .mem_en_o(en3), .mem_addr_o(maddr3), .mem_rdata_i(rdata3),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr));

    // RAM models: data appears only in the exact latency cycle after mem_en.
    always @(posedge clk) begin
        p1    <= en1 ? ram[maddr1[3:0]] : 32'hDEAD_BEEF;
        p3[0] <= en3 ? ram[maddr3[3:0]] : 32'hDEAD_BEEF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdata1 = p1;
    assign rdata3 = p3[2];

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One load seen by both instances; rd_req held for hold_cyc cycles.
    task automatic run_load(input string nm, input logic [31:0] addr,
                            input logic [1:0] sz, input bit sg,
                            input logic [31:0] exp_d, input bit exp_err,
                            input int hold_cyc, input bit wr_same);
        bit         hit, mem;
        int         vc1 = 0, vc3 = 0, vy1 = 0, vy3 = 0;
        int         ec1 = 0, ec3 = 0, ey1 = 0, ey3 = 0;
        logic [31:0] d1 = '0, d3 = '0;
        logic        e1 = 1'b0, e3 = 1'b0;
        logic [9:0]  a1 = '0, a3 = '0;
        hit = HOLD && !exp_err && !wr_same && mvld && (mtag == addr[31:2]);
        mem = !exp_err && !hit;
        @(negedge clk);
        rd_addr = addr; rd_size = sz; rd_sign = sg; rd_req = 1'b1;
        if (wr_same) begin wr_en = 1'b1; wr_addr = addr; end
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n >= hold_cyc) rd_req = 1'b0;
            wr_en = 1'b0;
            if (n == 1) begin
                check_eq({nm, " busy1"}, 32'(busy1), 32'd1);
                check_eq({nm, " busy3"}, 32'(busy3), 32'd1);
            end
            if (valid1) begin vc1++; if (vc1 == 1) begin vy1 = n; d1 = data1; e1 = err1; end end
            if (valid3) begin vc3++; if (vc3 == 1) begin vy3 = n; d3 = data3; e3 = err3; end end
            if (en1) begin ec1++; ey1 = n; a1 = maddr1; end
            if (en3) begin ec3++; ey3 = n; a3 = maddr3; end
        end
        check_eq({nm, " nvalid1"}, 32'(vc1), 32'd1);
        check_eq({nm, " nvalid3"}, 32'(vc3), 32'd1);
        check_eq({nm, " vcyc1"}, 32'(vy1), mem ? 32'd3 : 32'd1);
        check_eq({nm, " vcyc3"}, 32'(vy3), mem ? 32'd5 : 32'd1);
        check_eq({nm, " data1"}, d1, exp_d);
        check_eq({nm, " data3"}, d3, exp_d);
        check_eq({nm, " err1"}, 32'(e1), 32'(exp_err));
        check_eq({nm, " err3"}, 32'(e3), 32'(exp_err));
        check_eq({nm, " nmem1"}, 32'(ec1), 32'(mem));
        check_eq({nm, " nmem3"}, 32'(ec3), 32'(mem));
        if (mem) begin
            check_eq({nm, " memcyc1"}, 32'(ey1), 32'd1);
            check_eq({nm, " memcyc3"}, 32'(ey3), 32'd1);
            check_eq({nm, " maddr1"}, 32'(a1), 32'(addr[11:2]));
            check_eq({nm, " maddr3"}, 32'(a3), 32'(addr[11:2]));
            mvld = 1'b1;
            mtag = addr[31:2];
        end
    endtask

    task automatic check_idle_zero(input string nm);
        check_eq({nm, " busy1"},  32'(busy1),  32'd0);
        check_eq({nm, " valid1"}, 32'(valid1), 32'd0);
        check_eq({nm, " en1"},    32'(en1),    32'd0);
        check_eq({nm, " err1"},   32'(err1),   32'd0);
        check_eq({nm, " data1"},  data1,       32'd0);
        check_eq({nm, " maddr1"}, 32'(maddr1), 32'd0);
        check_eq({nm, " busy3"},  32'(busy3),  32'd0);
        check_eq({nm, " data3"},  data3,       32'd0);
        check_eq({nm, " maddr3"}, 32'(maddr3), 32'd0);
    endtask

    initial begin
        int vr;
        for (int i = 0; i < 16; i++) ram[i] = 32'h0101_0101 * i;
        ram[0] = 32'h1122_3344;
        ram[1] = 32'h80FF_7F00;
        ram[4] = 32'hCAFE_F00D;
        rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_size = '0;
        rd_sign = 1'b0; wr_en = 1'b0; wr_addr = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;

        run_load("w0",     32'h0000_0000, 2'b10, 1'b0, 32'h1122_3344, 1'b0, 1, 1'b0);
        run_load("sb7",    32'h0000_0007, 2'b00, 1'b1, 32'hFFFF_FF80, 1'b0, 1, 1'b0);
        run_load("ub7",    32'h0000_0007, 2'b00, 1'b0, 32'h0000_0080, 1'b0, 1, 1'b0);
        run_load("sh6",    32'h0000_0006, 2'b01, 1'b1, 32'hFFFF_80FF, 1'b0, 1, 1'b0);
        run_load("uh4",    32'h0000_0004, 2'b01, 1'b0, 32'h0000_7F00, 1'b0, 1, 1'b0);
        run_load("sb5",    32'h0000_0005, 2'b00, 1'b1, 32'h0000_007F, 1'b0, 1, 1'b0);
        run_load("sb6",    32'h0000_0006, 2'b00, 1'b1, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
        run_load("wmis",   32'h0000_0002, 2'b10, 1'b0, 32'h0000_0000, 1'b1, 1, 1'b0);
        run_load("region", 32'h1000_0000, 2'b10, 1'b0, 32'h0000_0000, 1'b1, 1, 1'b0);
        run_load("hmis",   32'h0000_0001, 2'b01, 1'b1, 32'h0000_0000, 1'b1, 1, 1'b0);
        run_load("sz11",   32'h0000_0000, 2'b11, 1'b0, 32'h0000_0000, 1'b1, 1, 1'b0);
        run_load("busyig", 32'h0000_0008, 2'b10, 1'b0, 32'h0202_0202, 1'b0, 4, 1'b0);

        // Reset while both instances sit in WAIT.
        @(negedge clk);
        rd_addr = 32'h0000_000C; rd_size = 2'b10; rd_sign = 1'b0; rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_zero("midrst");
        mvld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vr = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (valid1 || valid3) vr++;
        end
        check_eq("midrst novalid", 32'(vr), 32'd0);
        run_load("postrst", 32'h0000_000C, 2'b10, 1'b0, 32'h0303_0303, 1'b0, 1, 1'b0);

        // Last-read buffer behaviour (plain RAM loads when the option is off).
        run_load("buf_a",  32'h0000_0010, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 1, 1'b0);
        run_load("buf_b",  32'h0000_0010, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 1, 1'b0);
        run_load("buf_c",  32'h0000_0011, 2'b00, 1'b1, 32'hFFFF_FFF0, 1'b0, 1, 1'b0);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 32'h0000_0012;
        @(negedge clk);
        wr_en = 1'b0;
        if (mvld && (mtag == 30'h0000_0004)) mvld = 1'b0;
        run_load("buf_d",  32'h0000_0010, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 1, 1'b0);
        run_load("buf_e",  32'h0000_0010, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 1, 1'b1);
        run_load("buf_f",  32'h0000_0012, 2'b01, 1'b0, 32'h0000_CAFE, 1'b0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_rd_ctrl.md
Name: dmem_rd_ctrl

Overview:
- Read-side controller for the data memory; the counterpart of the store-path write-enable decode.
- Accepts one CPU load request at a time and checks region (addr[31:28] == REGION) and alignment.
- Issues a one-cycle read strobe to the synchronous data RAM and waits MEM_LAT cycles.
- Returns the byte, halfword or word, zero- or sign-extended, with a one-cycle valid pulse; the CPU stalls on busy.

Parameters:
- MEM_LAT, 1, RAM read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..4.
- AW, 10, word-address width of the RAM port.
- REGION, 4'h0, required value of addr[31:28] for a data-memory access.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_req  in  1  load request; sampled only when busy=0.
- rd_addr  in  32  byte address.
- rd_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- rd_sign  in  1  1 = sign-extend, 0 = zero-extend (byte/half only).
- busy  out  1  controller not idle; the CPU holds the pipeline.
- rd_valid  out  1  one-cycle response strobe.
- rd_data  out  32  extended load result; valid when rd_valid=1.
- rd_err  out  1  region/alignment/size error; valid when rd_valid=1.
- mem_en  out  1  RAM read strobe.
- mem_addr  out  AW  RAM word address = rd_addr[AW+1:2].
- mem_rdata  in  32  RAM read data.
- wr_en  in  1  store-path write enable (snooped).
- wr_addr  in  32  store-path byte address (snooped).

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, rd_valid, rd_err, mem_en = 0; rd_data, mem_addr = 0; the latency counter is cleared. Reset mid-operation abandons the pending load and produces no response.
- States:
  - IDLE: busy=0.
  - REQ: mem_en=1 for exactly this cycle.
  - WAIT: count MEM_LAT cycles.
  - RESP: rd_valid=1 for one cycle.
- IDLE, rd_req=1 with an error condition -> RESP.
  - Error conditions: addr[31:28] != REGION, size=11, half with addr[0]=1, or word with addr[1:0] != 0.
  - No mem_en is issued; rd_err=1, rd_data=0.
  - Latency: rd_valid is high in the cycle after the request cycle.
- IDLE, rd_req=1 with no error -> REQ.
  - Register the address, size and sign; drive mem_addr.
- REQ -> WAIT.
  - mem_addr is held until RESP.
- WAIT: counter counts MEM_LAT cycles, then mem_rdata is sampled and the state moves to RESP.
  - For MEM_LAT=1: request cycle 0, mem_en in cycle 1, data sampled at the end of cycle 2, rd_valid in cycle 3.
  - In general, rd_valid is high in cycle MEM_LAT+2.
- RESP -> IDLE.
  - rd_valid=1 and busy=1 during RESP.
  - rd_req is ignored whenever busy=1.
- Lane extraction (little-endian):
  - Byte lane = addr[1:0]; lane 0 is mem_rdata[7:0].
  - Half lane = addr[1]; 0 selects [15:0], 1 selects [31:16].
  - Sign extension uses bit 7 (byte) or bit 15 (half) when rd_sign=1; rd_sign is ignored for word loads.
- rd_data and rd_err hold their last values outside RESP; rd_valid qualifies them.
- Without the optional feature, wr_en and wr_addr are unused.

Optional Feature:
- Macro: DMEM_RD_HOLD_EN.
- Defined: a one-word last-read buffer (tag = addr[31:2], data, valid bit).
  - The buffer is filled on every memory-sourced RESP.
  - Hit: an error-free request whose tag matches while valid=1 skips REQ/WAIT and goes IDLE -> RESP, with rd_valid in the next cycle from buffered data and no mem_en.
  - Invalidation: any cycle with wr_en=1 and wr_addr[31:2] == tag clears valid.
  - A write to the same word in the same cycle as the request forces a miss.
  - A buffer fill and a matching write in the same cycle leave valid=0.
  - Reset clears valid.
- Not defined: no buffer; every error-free load goes through the RAM.

Test Plan:
- RAM word 0 = 0x11223344; word load addr 0x0000_0000, MEM_LAT=1 -> mem_en in cycle 1 with mem_addr=0; rd_valid in cycle 3, rd_data=0x11223344, rd_err=0.
- RAM word 1 = 0x80FF7F00; signed byte at 0x0000_0007 -> 0xFFFFFF80; unsigned byte at same address -> 0x00000080; signed half at 0x0000_0006 -> 0xFFFF80FF; unsigned half at 0x0000_0004 -> 0x00007F00.
- Word load at 0x0000_0002 and load at 0x1000_0000 -> no mem_en; rd_valid the next cycle with rd_err=1, rd_data=0.
- MEM_LAT=3: word load -> rd_valid exactly in cycle 5; a second rd_req during busy is ignored (one response only).
- rst_n low during WAIT -> all outputs 0 immediately; no rd_valid after release; the next request completes normally.
- DMEM_RD_HOLD_EN: load 0x0000_0010 twice -> second has no mem_en and rd_valid in cycle 1; then wr_en with wr_addr=0x0000_0012, reload -> mem_en issued again.
